leaf_stream_fifo: RTL and testbench
===================================

Name: leaf_stream_fifo

Overview:
- Leaf stage instantiated beneath the generated hierarchy nodes. Gives the otherwise empty leaves real sequential content.
- Buffers a valid/ready data stream between the producer leaf upstream and the consumer leaf downstream.
- Exposes live occupancy and a high-water mark so hierarchy-level benches can check traffic through every leaf.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- DEPTH, 4, number of storage entries; power of two, >=2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy and peak outputs. Derived; not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO accepts data this cycle.
- in_data  in  DATA_W  producer payload.
- out_valid  out  1  FIFO holds data for the consumer.
- out_ready  in  1  consumer takes data this cycle.
- out_data  out  DATA_W  head-of-queue payload.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- peak  out  CNT_W  maximum occupancy since reset or clear.
- peak_clr  in  1  synchronous clear of peak.

Behaviour:
- Reset (rst_n=0 at a rising edge): wr_ptr=0, rd_ptr=0, count=0, peak=0. After that edge: out_valid=0, in_ready=1.
  - While rst_n is low, in_ready is forced 0 combinationally, so no push is accepted.
  - Storage array contents are not reset; out_data is don't-care while out_valid=0.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Status: in_ready = (count != DEPTH) & rst_n. out_valid = (count != 0).
  - in_ready does not depend on out_ready: no full-pass-through.
  - out_valid does not depend on in_valid: no empty bypass.
- Latency: a word pushed into an empty FIFO at edge N gives out_valid=1 after edge N, with out_data equal to that word. Minimum latency is one cycle.
- out_data = mem[rd_ptr]; combinational read from the register array.
- Push: mem[wr_ptr] <= in_data. wr_ptr increments modulo DEPTH; wrap from DEPTH-1 to 0.
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or neither.
- Full (count=DEPTH): in_ready=0; a pop in this cycle frees one slot, visible next cycle.
- Empty (count=0): out_valid=0; out_ready is ignored and no pointer moves.
- Simultaneous push+pop at count=1: the head word leaves and the new word becomes head next cycle; count stays 1.
- Producer contract: in_data is held stable while in_valid=1 and in_ready=0. This is a bench assertion only; no RTL check.
- peak: each cycle, if next_count > peak then peak <= next_count. peak_clr=1 sets peak <= next_count, and takes priority over the compare.
- Reset mid-operation: any queued data is discarded. Pointers and counters return to reset values at that edge, with no partial transfer.
- No X propagation: every control register is reset.

Decomposition:
- Package leaf_fifo_pkg holds:
  - default DATA_W and DEPTH constants;
  - a ptr_w function (clog2 of DEPTH, min 1);
  - a fifo_status_t packed struct {full, empty, count} for hierarchy-level monitors.
- Single module, no sub-module; storage, pointers and peak tracker are under about 200 lines.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high -> count=0, peak=0, out_valid=0, in_ready=1.
- Fill then drain: DEPTH=4, push 0xA1..0xA4 with out_ready=0 -> in_ready=0 and count=4 after 4th edge. Then out_ready=1 -> out_data 0xA1,0xA2,0xA3,0xA4 on consecutive cycles; count falls to 0.
- Wrap: push/pop 10 words with random stalls -> output order matches input order across pointer wrap, and peak equals the max observed count.
- Full with simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop accepted and push refused that cycle. count=3 and in_ready=1 next cycle.
- Empty with push+ready: count=0, push 0x5C with out_ready=1 -> no pop that cycle. out_valid=1, out_data=0x5C, count=1 next cycle.
- Mid-stream reset and peak_clr: at count=3, assert rst_n=0 for one edge -> count=0, out_valid=0, and old data never appears. Then at peak=2, count=1, pulse peak_clr -> peak=1.

Source files
------------

// File: rtl/leaf_fifo_pkg.sv
// Shared constants, pointer sizing helper and status record for leaf stream FIFOs.
package leaf_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 4;
  localparam int unsigned STATUS_CNT_W   = $clog2(DEFAULT_DEPTH + 1);

  // Pointer width for a given depth; a depth of 1 still needs one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Snapshot used by hierarchy-level monitors.
  typedef struct packed {
    logic                    full;
    logic                    empty;
    logic [STATUS_CNT_W-1:0] count;
  } fifo_status_t;

endpackage

// File: rtl/leaf_stream_fifo.sv
// Valid/ready stream buffer with live occupancy and a clearable high-water mark.
module leaf_stream_fifo
  import leaf_fifo_pkg::*;
#(
  parameter  int unsigned DATA_W = DEFAULT_DATA_W,
  parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  peak,
  input  logic              peak_clr
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  peak_q, peak_d;
  logic              push, pop;

  // Handshake status straight from occupancy; in_ready is held low during reset.
  always_comb begin
    in_ready  = (count_q != CNT_W'(DEPTH)) & rst_n;
    out_valid = (count_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_data  = mem_q[rd_ptr_q];
    count     = count_q;
    peak      = peak_q;
  end

  // Next-state for pointers, occupancy and the high-water mark.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    peak_d   = peak_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (peak_clr) begin
      peak_d = count_d;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
  end

  // Control registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
    end
  end

  // Storage array; not reset, writes only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Directed bench for leaf_stream_fifo (DATA_W=8, DEPTH=4).
module tb_leaf_stream_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
  logic [2:0] peak;
  logic       peak_clr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  leaf_stream_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .peak     (peak),
    .peak_clr (peak_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Producer contract: payload held while a valid word is stalled.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(posedge clk) begin
    if (rst_n && prev_stall && in_valid) begin
      assert (in_data === prev_data) else begin
        n_errors++;
        $error("FAIL producer_hold: observed 0x%0h expected 0x%0h", in_data, prev_data);
      end
    end
    prev_stall = in_valid && !in_ready;
    prev_data  = in_data;
  end

  initial begin
    int unsigned sent, rcvd, mcount, mpeak;
    logic        mpush, mpop;
    logic [7:0]  sb [$];
    logic [15:0] vpat;
    logic [15:0] rpat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    peak_clr  = 1'b0;

    // Reset held for two edges, then idle.
    step();
    chk("rst_in_ready_low", in_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_peak", peak, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);

    // Fill with A1..A4, consumer stalled.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA1 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_peak", peak, 4);
    chk("fill_out_valid", out_valid, 1);

    // Drain in order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_count", count, 32'(4 - i));
      chk("drain_data", out_data, 32'(8'hA1 + 8'(i)));
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty_count", count, 0);
    chk("drain_empty_valid", out_valid, 0);

    // Full with simultaneous pop: push refused, pop accepted.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hB1 + 8'(i);
      step();
    end
    in_data   = 8'hC5;
    out_ready = 1'b1;
    chk("full_pop_in_ready", in_ready, 0);
    chk("full_pop_head", out_data, 8'hB1);
    step();
    chk("full_pop_count", count, 3);
    chk("full_pop_in_ready_after", in_ready, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("full_pop_drain", out_data, 32'(8'hB2 + 8'(i)));
      step();
    end
    chk("full_pop_drained", count, 0);

    // Empty with push and consumer ready: no pop that cycle.
    in_valid  = 1'b1;
    in_data   = 8'h5C;
    out_ready = 1'b1;
    chk("empty_out_valid", out_valid, 0);
    step();
    chk("empty_push_valid", out_valid, 1);
    chk("empty_push_data", out_data, 8'h5C);
    chk("empty_push_count", count, 1);

    // Push and pop together at count 1: new word becomes head.
    in_data = 8'h6D;
    step();
    chk("one_pushpop_count", count, 1);
    chk("one_pushpop_data", out_data, 8'h6D);
    in_valid = 1'b0;
    step();
    chk("one_pushpop_drain", count, 0);
    out_ready = 1'b0;

    // Clear peak at empty before the wrap run.
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    chk("peak_clr_empty", peak, 0);

    // Ten words with stall patterns, crossing the pointer wrap.
    vpat   = 16'b1011_0111_1101_1010;
    rpat   = 16'b0110_0001_0011_1000;
    sent   = 0;
    rcvd   = 0;
    mcount = 0;
    mpeak  = 0;
    for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
      in_valid  = (sent < 10) && vpat[cyc % 16];
      in_data   = 8'h30 + 8'(sent);
      out_ready = rpat[cyc % 16];
      mpush = in_valid && (mcount != 4);
      mpop  = (mcount != 0) && out_ready;
      chk("wrap_count", count, mcount);
      chk("wrap_in_ready", in_ready, (mcount != 4) ? 1 : 0);
      if (mpop) chk("wrap_data", out_data, 32'(sb[0]));
      step();
      if (mpush) begin
        sb.push_back(in_data);
        sent++;
      end
      if (mpop) begin
        void'(sb.pop_front());
        rcvd++;
      end
      if (mpush && !mpop) mcount++;
      if (mpop && !mpush) mcount--;
      if (mcount > mpeak) mpeak = mcount;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("wrap_all_received", rcvd, 10);
    chk("wrap_peak", peak, mpeak);

    // Mid-stream reset at count 3 discards queued data.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hE1 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("mid_pre_count", count, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready_low", in_ready, 0);
    step();
    chk("mid_count", count, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_peak", peak, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 8'hF1;
    step();
    chk("mid_new_head", out_data, 8'hF1);
    in_data = 8'hF2;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("peak_before_clr", peak, 2);
    chk("count_before_clr", count, 1);
    chk("head_after_pop", out_data, 8'hF2);
    peak_clr = 1'b1;
    step();
    peak_clr = 1'b0;
    chk("peak_after_clr", peak, 1);
    chk("count_after_clr", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
